// File: rtl/contador_pkg.sv
// Shared constants and types for the parametrised up/down counter family.
package contador_pkg;

   // Boundary behaviour selected by the MODE parameter.
   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   // Legal range of the WIDTH parameter.
   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 16;

   // Meaning of the up_dn input.
   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

endpackage

// File: rtl/contador_next_logic.sv
// Combinational next-count and boundary computation for one enabled step.
// The result is only meaningful when the parent decides to take an enabled
// step; reset and load priority live in the parent.
module contador_next_logic
   import contador_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int MODE  = MODE_WRAP
) (
   input  logic [WIDTH-1:0] count,
   input  logic [WIDTH-1:0] limit,
   input  logic             up_dn,
   output logic [WIDTH-1:0] count_step,
   output logic             at_bound
);

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   logic above_limit;

   // Boundary: >= on the way up also catches a count left above a lowered limit.
   always_comb begin
      above_limit = (count > limit);
      if (up_dn == DIR_UP) begin
         at_bound = (count >= limit);
      end else begin
         at_bound = (count == ZERO);
      end
   end

   // Next count for an enabled step; boundary is checked first so no overflow.
   always_comb begin
      count_step = count;
      if (up_dn == DIR_UP) begin
         if (!at_bound) begin
            count_step = count + ONE;
         end else if (MODE == MODE_WRAP) begin
            count_step = ZERO;
         end else begin
            // Saturate: hold, but pull an out-of-range count back to limit.
            count_step = above_limit ? limit : count;
         end
      end else begin
         if (count != ZERO) begin
            count_step = above_limit ? limit : (count - ONE);
         end else if (MODE == MODE_WRAP) begin
            count_step = limit;
         end else begin
            count_step = ZERO;
         end
      end
   end

endmodule

// File: rtl/contador_param_updown.sv
// Parametrised up/down modulo counter with runtime limit, parallel load,
// wrap/saturate boundary mode and a registered terminal-count pulse.
// WIDTH is legal in WIDTH_MIN..WIDTH_MAX; RESET_VAL must fit in WIDTH bits.
module contador_param_updown
   import contador_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MODE      = MODE_WRAP,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             at_bound
);

   localparam logic [WIDTH-1:0] RESET_CNT = RESET_VAL[WIDTH-1:0];

   logic [WIDTH-1:0] count_step;
   logic [WIDTH-1:0] load_clip;

   contador_next_logic #(
      .WIDTH (WIDTH),
      .MODE  (MODE)
   ) u_next (
      .count      (count),
      .limit      (limit),
      .up_dn      (up_dn),
      .count_step (count_step),
      .at_bound   (at_bound)
   );

   // Loaded values are clamped into the legal range 0..limit.
   always_comb begin
      load_clip = (load_val > limit) ? limit : load_val;
   end

   // Count/tc registers with reset > load > en priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= RESET_CNT;
         tc    <= 1'b0;
      end else if (load) begin
         count <= load_clip;
         tc    <= 1'b0;
      end else if (en) begin
         count <= count_step;
         tc    <= at_bound;
      end else begin
         tc    <= 1'b0;
      end
   end

endmodule

// File: doc/contador_param_updown.md
Name: contador_param_updown

Overview:
- Parametrised successor to the team's fixed 4-bit, limit-12 ascending counter.
- Adds:
  - configurable width;
  - runtime-programmable limit;
  - up/down direction;
  - count enable;
  - parallel load;
  - wrap or saturate mode;
  - a registered terminal-count pulse for cascading.
- Used wherever the design needs modulo-N sequencing, such as display multiplexing, timers and step sequencers.

Parameters:
- WIDTH, 4, bit width of count, load_val and limit (legal range 2..16).
- MODE, 0, 0 = wrap at the boundary; 1 = saturate (hold) at the boundary.
- RESET_VAL, 0, value count takes on reset; must be ≤ 2^WIDTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; count steps only when high.
- up_dn  in  1  direction: 1 = up, 0 = down.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value to load.
- limit  in  WIDTH  inclusive upper bound of the count range 0..limit.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered.
- at_bound  out  1  combinational: count is at the boundary for the current direction.

Behaviour:
- Reset is synchronous and active-high:
  - On a clk edge with reset=1: count <= RESET_VAL, tc <= 0.
  - reset overrides all other inputs, including mid-count and during load.
- Priority per edge: reset > load > en. With en=0 and load=0, count holds and tc <= 0.
- Load:
  - count <= min(load_val, limit); tc <= 0.
  - Load ignores en and up_dn.
- Boundary definition:
  - at_bound = (up_dn & count >= limit) | (~up_dn & count == 0).
  - The ≥ comparison covers count > limit after limit is lowered at runtime. That case is treated as the boundary; no out-of-range count persists past one enabled up step.
- Up step (en=1, up_dn=1):
  - If !at_bound: count <= count+1.
  - Else if MODE=0: count <= 0.
  - Else (MODE=1): count holds its value, unchanged from limit unless limit was lowered, and is then forced to limit.
- Down step (en=1, up_dn=0):
  - If count != 0: count <= count-1.
    - If count > limit (limit lowered at runtime), count <= limit instead.
  - Else if MODE=0: count <= limit.
  - Else (MODE=1): count holds at 0.
- tc:
  - tc <= en & ~load & at_bound, evaluated at the edge.
  - tc is high for exactly one cycle per boundary event in wrap mode. That cycle coincides with the first cycle of the wrapped value.
  - In saturate mode, tc stays high every enabled cycle while held at the boundary.
- limit = 0:
  - Count is always 0.
  - In MODE=0, tc pulses on every enabled cycle.
- Direction change mid-count takes effect on the next enabled edge; no extra latency.
- Arithmetic:
  - All operations are WIDTH bits, unsigned.
  - No intermediate overflow is possible, because the boundary is checked before the increment or decrement.
- Latency:
  - count and tc update one cycle after the inputs are sampled.
  - at_bound reflects the current count with zero latency.

Decomposition:
- Shared package, contador_pkg:
  - MODE_WRAP = 0, MODE_SAT = 1;
  - width-legality constants (WIDTH_MIN = 2, WIDTH_MAX = 16).
- One natural sub-module, contador_next_logic: the combinational next-count and boundary computation.
- The parent module holds the registers and the reset/load priority.

Test Plan:
- WIDTH=4, MODE=0, limit=12, up, en=1 from reset → count steps 0,1,…,12,0,1. tc=1 only in the cycle count shows 0 after 12.
- Same configuration, down from count=0 → count steps 12,11,…,0,12. tc pulses in the cycle count shows 12.
- MODE=1, limit=5, up for 10 cycles → count reaches 5 and holds. tc is high on every enabled cycle from the first hold onward. Down then releases: 4,3,…,0, and it holds at 0.
- load=1, load_val=14, limit=9 → count=9 next cycle, tc=0. Then load with load_val=3, en=1 in the same cycle → count=3 (load wins).
- count=10, limit lowered to 6, en=1, up → count=0 (MODE=0), tc=1. A second run with down from count=10 → count=6.
- Reset asserted at count=7 while en=1 and load=1 → count=RESET_VAL and tc=0 on the next edge. Counting resumes from RESET_VAL the cycle after reset deasserts.
